// File: rtl/msg_bit_packer.sv
// msg_bit_packer
//   Packs the serial message bits coming out of the constant-weight decoder into
//   MSG_W-bit words. The first bit received lands in the MSB. On the decoder's
//   done pulse, any partial word is flushed left-aligned. If no bits are pending
//   at that point, a zero-length marker word is pushed instead, so every message
//   ends with exactly one word that has last=1.
//   Words are held in a small FIFO with a valid/ready head. The decoder cannot be
//   stalled, so a word pushed into a full FIFO is dropped and the sticky overflow
//   flag is set.
//
// Ports
//   clk        single clock, all logic on posedge
//   rst        synchronous reset, active-high
//   bin_msg    decoded message bit
//   msg_vld    bin_msg qualifier
//   dec_done   end-of-message pulse from the decoder
//   out_data   FIFO head word, first bit in MSB, unused LSBs zero
//   out_nbits  number of valid bits in out_data (0..MSG_W)
//   out_last   head word closes a message
//   out_valid  FIFO not empty
//   out_ready  consumer accepts the head word
//   overflow   sticky, a word was dropped
//   busy       partial word pending
//
// State | meaning
// IDLE  | no bits pending
// FILL  | 1..MSG_W-1 bits held in the shift register
module msg_bit_packer #(
  parameter int MSG_W = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bin_msg,
  input  logic             msg_vld,
  input  logic             dec_done,
  output logic [MSG_W-1:0] out_data,
  output logic [CNT_W-1:0] out_nbits,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MSG_W_C = CNT_W'(MSG_W);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);

  state_t             state, state_nxt;
  logic [MSG_W-1:0]   shreg, shreg_nxt, shreg_shift;
  logic [CNT_W-1:0]   cnt, cnt_nxt, bits_after;

  logic               push;
  logic [MSG_W-1:0]   push_data;
  logic [CNT_W-1:0]   push_nbits;
  logic               push_last;

  logic [MSG_W-1:0]   mem_data  [DEPTH];
  logic [CNT_W-1:0]   mem_nbits [DEPTH];
  logic               mem_last  [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               full, pop, push_ok;

  // ---------------- packer FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    push        = 1'b0;
    push_data   = '0;
    push_nbits  = '0;
    push_last   = 1'b0;

    // The bit arriving this cycle is counted before any flush decision.
    shreg_shift = msg_vld ? {shreg[MSG_W-2:0], bin_msg} : shreg;
    bits_after  = msg_vld ? cnt + CNT_W'(1) : cnt;

    case (state)
      IDLE: if (msg_vld) state_nxt = FILL;
      FILL: state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase

    if (msg_vld) begin
      shreg_nxt = shreg_shift;
      cnt_nxt   = bits_after;
    end

    if (bits_after == MSG_W_C) begin
      push       = 1'b1;
      push_data  = shreg_shift;
      push_nbits = MSG_W_C;
      push_last  = dec_done;
      shreg_nxt  = '0;
      cnt_nxt    = '0;
      state_nxt  = IDLE;
    end else if (dec_done) begin
      // Left-align the k pending bits; with k=0 this yields the zero marker word.
      push       = 1'b1;
      push_data  = shreg_shift << (MSG_W_C - bits_after);
      push_nbits = bits_after;
      push_last  = 1'b1;
      shreg_nxt  = '0;
      cnt_nxt    = '0;
      state_nxt  = IDLE;
    end
  end

  assign busy = (state == FILL);

  // ---------------- output FIFO ----------------
  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_nbits[i] <= '0;
        mem_last[i]  <= 1'b0;
      end
    end else begin
      if (push_ok) begin
        mem_data[wr_ptr]  <= push_data;
        mem_nbits[wr_ptr] <= push_nbits;
        mem_last[wr_ptr]  <= push_last;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign out_data  = out_valid ? mem_data[rd_ptr]  : '0;
  assign out_nbits = out_valid ? mem_nbits[rd_ptr] : '0;
  assign out_last  = out_valid ? mem_last[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_msg_bit_packer.sv
module tb_msg_bit_packer;

  logic       clk;
  logic       rst;
  logic       bin_msg;
  logic       msg_vld;
  logic       dec_done;
  logic [7:0] out_data;
  logic [3:0] out_nbits;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       busy;

  int n_checks;
  int n_errors;

  msg_bit_packer #(.MSG_W(8), .DEPTH(4), .AW(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_msg   (bin_msg),
    .msg_vld   (msg_vld),
    .dec_done  (dec_done),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic done);
    bin_msg  = b;
    msg_vld  = 1'b1;
    dec_done = done;
    tick();
    msg_vld  = 1'b0;
    dec_done = 1'b0;
    bin_msg  = 1'b0;
  endtask

  task automatic done_pulse();
    dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
  endtask

  // Sends a full byte MSB first; optionally raises dec_done and/or out_ready on the last bit.
  task automatic send_word(input logic [7:0] w, input logic done_last, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && rdy_last) out_ready = 1'b1;
      send_bit(w[i], done_last && (i == 0));
    end
    out_ready = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d, input logic [3:0] n,
                            input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_nbits"}, 32'(out_nbits), 32'(n));
    check({tag, "_last"},  32'(out_last),  32'(l));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bin_msg   = 1'b0;
    msg_vld   = 1'b0;
    dec_done  = 1'b0;
    out_ready = 1'b0;
    #1;
    do_reset();

    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_data",     32'(out_data),  32'd0);

    // Reset mid-fill drops the pending bits.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("fill_busy", 32'(busy), 32'd1);
    do_reset();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ovf",   32'(overflow),  32'd0);
    check("midrst_busy",  32'(busy),      32'd0);
    done_pulse();
    pop_expect("midrst_marker", 8'h00, 4'd0, 1'b1);
    check("midrst_empty", 32'(out_valid), 32'd0);

    // Full word, later done -> word then marker.
    send_word(8'hB2, 1'b0, 1'b0);
    check("b2_lat_valid", 32'(out_valid), 32'd1);
    check("b2_busy",      32'(busy),      32'd0);
    tick();
    tick();
    done_pulse();
    pop_expect("b2_word",   8'hB2, 4'd8, 1'b0);
    pop_expect("b2_marker", 8'h00, 4'd0, 1'b1);
    check("b2_empty",      32'(out_valid), 32'd0);
    check("b2_empty_data", 32'(out_data),  32'd0);

    // Partial word flushed with done on the 3rd bit.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check("c0_busy", 32'(busy), 32'd0);
    pop_expect("c0_word", 8'hC0, 4'd3, 1'b1);
    check("c0_empty", 32'(out_valid), 32'd0);

    // Single-bit partial word.
    send_bit(1'b1, 1'b1);
    pop_expect("k1_word", 8'h80, 4'd1, 1'b1);

    // 8th bit and done together -> one word, no marker.
    send_word(8'h5A, 1'b1, 1'b0);
    pop_expect("5a_word", 8'h5A, 4'd8, 1'b1);
    check("5a_nomarker", 32'(out_valid), 32'd0);

    // Overflow: five words into a four-deep FIFO.
    for (int w = 1; w <= 4; w++) send_word(8'(w), 1'b0, 1'b0);
    check("ovf_before", 32'(overflow), 32'd0);
    send_word(8'h05, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    for (int w = 1; w <= 4; w++) pop_expect("ovf_pop", 8'(w), 4'd8, 1'b0);
    check("ovf_drained", 32'(out_valid), 32'd0);
    check("ovf_sticky",  32'(overflow),  32'd1);
    do_reset();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, pop in the same cycle a word completes.
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b1);
    check("pp_overflow", 32'(overflow), 32'd0);
    pop_expect("pp_pop0", 8'h22, 4'd8, 1'b0);
    pop_expect("pp_pop1", 8'h33, 4'd8, 1'b0);
    pop_expect("pp_pop2", 8'h44, 4'd8, 1'b0);
    pop_expect("pp_pop3", 8'h55, 4'd8, 1'b0);
    check("pp_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
